// File: rtl/opc_intctl.sv
// ---------------------------------------------------------------------------
// opc_intctl -- vectored, prioritised interrupt controller for the OPC CPUs.
//
// Sits on the CPU data bus as an 8-word memory-mapped slave. NCHAN interrupt
// sources are synchronised, latched into PEND (edge or level per channel),
// masked, and arbitrated with channel 0 highest. Nested preemption is allowed
// only by channels of strictly higher priority than the highest in-service
// channel. The winner drives an active-low request and a handler vector.
//
// Ports
//   clk      in   system clock
//   reset_b  in   synchronous active-low reset (acts regardless of clken)
//   clken    in   clock enable; all state holds while low
//   irq      in   [NCHAN]  asynchronous interrupt sources, active high
//   address  in   [WIDTH]  CPU bus address
//   din      in   [WIDTH]  CPU write data
//   rnw      in   1 = read, 0 = write
//   vda      in   valid data address strobe
//   dout     out  [WIDTH]  read data, 0 when not selected (OR-able onto bus)
//   sel      out  register block addressed this cycle
//   int_b    out  registered active-low interrupt request
//   vector   out  [WIDTH]  VEC_BASE + id*VEC_STRIDE for the current winner
//
// Register map (address[2:0]):
//   0 PEND   R, W1C on edge channels     4 EOI    W, retire top in-service
//   1 MASK   R/W, 1 = enabled            5 INSVC  R
//   2 MODE   R/W, 1 = edge, 0 = level    6 VECTOR R
//   3 ID     R, {valid, id}; reading claims the winner      7 reserved
// ---------------------------------------------------------------------------
module opc_intctl #(
  parameter int               WIDTH      = 24,
  parameter int               NCHAN      = 8,
  parameter logic [WIDTH-1:0] BASE       = 24'hFFFF00,
  parameter logic [WIDTH-1:0] VEC_BASE   = 24'h000010,
  parameter int               VEC_STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             clken,
  input  logic [NCHAN-1:0] irq,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] din,
  input  logic             rnw,
  input  logic             vda,
  output logic [WIDTH-1:0] dout,
  output logic             sel,
  output logic             int_b,
  output logic [WIDTH-1:0] vector
);

  localparam int ID_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [2:0] {
    REG_PEND   = 3'd0,
    REG_MASK   = 3'd1,
    REG_MODE   = 3'd2,
    REG_ID     = 3'd3,
    REG_EOI    = 3'd4,
    REG_INSVC  = 3'd5,
    REG_VECTOR = 3'd6,
    REG_NONE   = 3'd7
  } reg_e;

  logic [NCHAN-1:0] sync1, sync2, prev;
  logic [NCHAN-1:0] pend, mask, mode, insvc;
  logic [NCHAN-1:0] rise, allowed, cand, claim_set, eoi_clr, w1c_bits, pend_edge;
  logic [ID_W-1:0]  win_id;
  logic             valid;
  reg_e             reg_sel;
  logic             wr_en, claim, eoi;
  logic [WIDTH-1:0] id_word;
  logic             unused_din;

  assign sel     = vda && (address[WIDTH-1:3] == BASE[WIDTH-1:3]);
  assign reg_sel = reg_e'(address[2:0]);
  assign wr_en   = sel && !rnw && clken;
  assign claim   = sel && rnw && clken && (reg_sel == REG_ID) && valid;
  assign eoi     = wr_en && (reg_sel == REG_EOI);

  // Only the low NCHAN data bits carry channel information.
  assign unused_din = &{1'b0, din[WIDTH-1:NCHAN]};

  assign rise = sync2 & ~prev;

  // Channels strictly above the highest-priority in-service channel: the
  // bits below the lowest set INSVC bit (all ones when INSVC is empty).
  assign allowed = ~insvc & (insvc - 1'b1);
  assign cand    = pend & mask & allowed;
  assign valid   = |cand;

  // Isolate the lowest set bit: winner to claim, top in-service to retire.
  assign claim_set = claim ? (cand & (~cand + 1'b1)) : '0;
  assign eoi_clr   = eoi ? (insvc & (~insvc + 1'b1)) : '0;

  assign w1c_bits  = (wr_en && (reg_sel == REG_PEND)) ? din[NCHAN-1:0] : '0;
  // A fresh edge is OR-ed in last so it survives a same-cycle W1C or claim.
  assign pend_edge = (pend & ~w1c_bits & ~claim_set) | rise;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_id = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    id_word            = '0;
    id_word[WIDTH-1]   = valid;
    id_word[ID_W-1:0]  = win_id;
  end

  assign vector = VEC_BASE + WIDTH'(win_id) * WIDTH'(VEC_STRIDE);

  always_comb begin
    dout = '0;
    if (sel) begin
      case (reg_sel)
        REG_PEND:   dout = WIDTH'(pend);
        REG_MASK:   dout = WIDTH'(mask);
        REG_MODE:   dout = WIDTH'(mode);
        REG_ID:     dout = id_word;
        REG_INSVC:  dout = WIDTH'(insvc);
        REG_VECTOR: dout = vector;
        default:    dout = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values (the sync1 -> sync2 -> prev chain depends on it).
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      insvc <= '0;
      int_b <= 1'b1;
    end else if (clken) begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
      // Edge channels latch; level channels follow the synchronised input.
      pend  <= (mode & pend_edge) | (~mode & sync2);
      insvc <= (insvc & ~eoi_clr) | claim_set;
      if (wr_en && (reg_sel == REG_MASK)) mask <= din[NCHAN-1:0];
      if (wr_en && (reg_sel == REG_MODE)) mode <= din[NCHAN-1:0];
      int_b <= ~valid;
    end
  end

endmodule

// File: tb/tb_opc_intctl.sv
// ---------------------------------------------------------------------------
// tb_opc_intctl -- self-checking bench for opc_intctl (default parameters).
// Directed table of bus operations with hand-derived expectations, a few
// multi-cycle corner sequences, then randomized traffic against a
// behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_opc_intctl;

  localparam int          NCHAN      = 8;
  localparam logic [23:0] BASE       = 24'hFFFF00;
  localparam logic [23:0] VEC_BASE   = 24'h000010;
  localparam int          VEC_STRIDE = 2;

  logic        clk = 1'b0;
  logic        reset_b, clken, rnw, vda;
  logic [7:0]  irq;
  logic [23:0] address, din;
  logic [23:0] dout, vector;
  logic        sel, int_b;

  opc_intctl dut (
    .clk     (clk),
    .reset_b (reset_b),
    .clken   (clken),
    .irq     (irq),
    .address (address),
    .din     (din),
    .rnw     (rnw),
    .vda     (vda),
    .dout    (dout),
    .sel     (sel),
    .int_b   (int_b),
    .vector  (vector)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_s1, m_s2, m_prev, m_pend, m_mask, m_mode, m_insvc;
  logic       m_int_b;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < NCHAN; i++) if (v[i]) return i;
    return NCHAN;
  endfunction

  // Winner: lowest enabled pending channel above the top in-service one.
  function automatic int m_winner();
    int h = lowest(m_insvc);
    for (int i = 0; i < h; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic m_sel();
    return vda && ((address >> 3) == (BASE >> 3));
  endfunction

  function automatic logic [23:0] m_vector();
    int w = m_winner();
    if (w < 0) w = 0;
    return VEC_BASE + 24'(w * VEC_STRIDE);
  endfunction

  function automatic logic [23:0] m_dout();
    int w = m_winner();
    if (!m_sel()) return 24'h0;
    case (address[2:0])
      3'd0:    return {16'h0, m_pend};
      3'd1:    return {16'h0, m_mask};
      3'd2:    return {16'h0, m_mode};
      3'd3:    return (w < 0) ? 24'h0 : (24'h800000 | 24'(w));
      3'd5:    return {16'h0, m_insvc};
      3'd6:    return m_vector();
      default: return 24'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int         w;
    logic       s;
    logic [2:0] off;
    logic [7:0] p;
    if (!reset_b) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_pend = 0;
      m_mask = 0; m_mode = 0; m_insvc = 0; m_int_b = 1'b1;
      return;
    end
    if (!clken) return;
    w   = m_winner();
    s   = m_sel();
    off = address[2:0];
    p   = m_pend;
    for (int i = 0; i < NCHAN; i++) begin
      if (m_mode[i]) begin
        if (s && !rnw && off == 3'd0 && din[i]) p[i] = 1'b0;
        if (s && rnw && off == 3'd3 && w == i) p[i] = 1'b0;
        if (m_s2[i] && !m_prev[i]) p[i] = 1'b1;
      end else begin
        p[i] = m_s2[i];
      end
    end
    if (s && rnw && off == 3'd3 && w >= 0) m_insvc[w] = 1'b1;
    if (s && !rnw && off == 3'd4 && m_insvc != 0) m_insvc[lowest(m_insvc)] = 1'b0;
    if (s && !rnw && off == 3'd1) m_mask = din[7:0];
    if (s && !rnw && off == 3'd2) m_mode = din[7:0];
    m_int_b = (w < 0);
    m_prev  = m_s2;
    m_s2    = m_s1;
    m_s1    = irq;
    m_pend  = p;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // One bus access; read data is sampled before the edge that completes it.
  task automatic bus(input logic wr, input logic [2:0] off, input logic [23:0] data,
                     output logic [23:0] rd);
    address = BASE | 24'(off);
    rnw     = !wr;
    vda     = 1'b1;
    din     = data;
    #1;
    rd = dout;
    tick();
    vda = 1'b0;
    rnw = 1'b1;
    din = 24'h0;
  endtask

  // ---------------- directed table ----------------
  typedef enum int {OP_IDLE, OP_WR, OP_RD} op_e;
  typedef struct {
    string       name;
    op_e         op;
    logic [2:0]  off;
    logic [23:0] wdata;
    logic [7:0]  irq;
    int          n;
    logic [23:0] exp_rd;
    logic        exp_int_b;
  } row_t;

  row_t tbl[$];

  task automatic add(input string name, input op_e op, input logic [2:0] off,
                     input logic [23:0] wdata, input logic [7:0] irqv, input int n,
                     input logic [23:0] exp_rd, input logic exp_ib);
    row_t r;
    r.name = name; r.op = op; r.off = off; r.wdata = wdata; r.irq = irqv;
    r.n = n; r.exp_rd = exp_rd; r.exp_int_b = exp_ib;
    tbl.push_back(r);
  endtask

  logic [23:0] rd;

  initial begin
    reset_b = 1'b0; clken = 1'b1; irq = 8'h0;
    address = 24'h0; din = 24'h0; rnw = 1'b1; vda = 1'b0;
    tick();
    tick();
    reset_b = 1'b1;

    // Reset state
    check("reset int_b", int_b, 1'b1);
    check("reset vector", vector, VEC_BASE);
    check("reset sel idle", sel, 1'b0);
    check("reset dout idle", dout, 24'h0);
    bus(0, 3'd0, 0, rd); check("reset PEND", rd, 24'h0);
    bus(0, 3'd1, 0, rd); check("reset MASK", rd, 24'h0);
    bus(0, 3'd2, 0, rd); check("reset MODE", rd, 24'h0);
    bus(0, 3'd5, 0, rd); check("reset INSVC", rd, 24'h0);

    // Edge channel 0: latency, claim, EOI
    add("s1 mask",     OP_WR,   3'd1, 24'h01, 8'h00, 0, 0,        1'b1);
    add("s1 mode",     OP_WR,   3'd2, 24'h01, 8'h00, 0, 0,        1'b1);
    add("s1 rise",     OP_IDLE, 3'd0, 0,      8'h01, 1, 0,        1'b1);
    add("s1 fall",     OP_IDLE, 3'd0, 0,      8'h00, 1, 0,        1'b1);
    add("s1 pend k+1", OP_RD,   3'd0, 0,      8'h00, 0, 24'h0,    1'b1);
    add("s1 pend k+2", OP_RD,   3'd0, 0,      8'h00, 0, 24'h1,    1'b0);
    add("s1 claim",    OP_RD,   3'd3, 0,      8'h00, 0, 24'h800000, 1'b0);
    add("s1 insvc",    OP_RD,   3'd5, 0,      8'h00, 0, 24'h01,   1'b1);
    add("s1 pend clr", OP_RD,   3'd0, 0,      8'h00, 0, 24'h00,   1'b1);
    add("s1 eoi",      OP_WR,   3'd4, 0,      8'h00, 0, 0,        1'b1);
    add("s1 insvc 0",  OP_RD,   3'd5, 0,      8'h00, 0, 24'h00,   1'b1);
    // Level channel 5, preempted by level channel 2
    add("s2 mask",     OP_WR,   3'd1, 24'hFF, 8'h00, 0, 0,        1'b1);
    add("s2 lvl5",     OP_IDLE, 3'd0, 0,      8'h20, 3, 0,        1'b1);
    add("s2 req5",     OP_IDLE, 3'd0, 0,      8'h20, 1, 0,        1'b0);
    add("s2 claim5",   OP_RD,   3'd3, 0,      8'h20, 0, 24'h800005, 1'b0);
    add("s2 ack5",     OP_IDLE, 3'd0, 0,      8'h20, 1, 0,        1'b1);
    add("s2 lvl2",     OP_IDLE, 3'd0, 0,      8'h24, 3, 0,        1'b1);
    add("s2 req2",     OP_IDLE, 3'd0, 0,      8'h24, 1, 0,        1'b0);
    add("s2 vector",   OP_RD,   3'd6, 0,      8'h24, 0, 24'h000014, 1'b0);
    add("s2 claim2",   OP_RD,   3'd3, 0,      8'h24, 0, 24'h800002, 1'b0);
    add("s2 insvc24",  OP_RD,   3'd5, 0,      8'h20, 0, 24'h24,   1'b1);
    add("s2 drop2",    OP_IDLE, 3'd0, 0,      8'h20, 3, 0,        1'b1);
    add("s2 eoi a",    OP_WR,   3'd4, 0,      8'h20, 0, 0,        1'b1);
    add("s2 insvc20",  OP_RD,   3'd5, 0,      8'h20, 0, 24'h20,   1'b1);
    add("s2 eoi b",    OP_WR,   3'd4, 0,      8'h20, 0, 0,        1'b1);
    add("s2 insvc0",   OP_RD,   3'd5, 0,      8'h20, 0, 24'h00,   1'b0);
    // Preemption blocked by in-service channel 2
    add("s3 swap",     OP_IDLE, 3'd0, 0,      8'h04, 4, 0,        1'b0);
    add("s3 claim2",   OP_RD,   3'd3, 0,      8'h04, 0, 24'h800002, 1'b0);
    add("s3 lvl6",     OP_IDLE, 3'd0, 0,      8'h44, 4, 0,        1'b1);
    add("s3 id none",  OP_RD,   3'd3, 0,      8'h44, 0, 24'h0,    1'b1);
    add("s3 insvc",    OP_RD,   3'd5, 0,      8'h44, 0, 24'h04,   1'b1);
    add("s3 eoi",      OP_WR,   3'd4, 0,      8'h44, 0, 0,        1'b1);
    add("s3 unblock",  OP_IDLE, 3'd0, 0,      8'h44, 1, 0,        1'b0);
    add("s3 quiet",    OP_IDLE, 3'd0, 0,      8'h00, 4, 0,        1'b1);

    foreach (tbl[i]) begin
      irq = tbl[i].irq;
      case (tbl[i].op)
        OP_IDLE: repeat (tbl[i].n) tick();
        OP_WR:   bus(1, tbl[i].off, tbl[i].wdata, rd);
        default: begin
          bus(0, tbl[i].off, 0, rd);
          check({tbl[i].name, " rd"}, rd, tbl[i].exp_rd);
        end
      endcase
      check({tbl[i].name, " int_b"}, int_b, tbl[i].exp_int_b);
    end

    // W1C colliding with a new edge on channel 3
    bus(1, 3'd2, 24'h08, rd);
    irq = 8'h08;
    tick();
    tick();
    bus(1, 3'd0, 24'h08, rd);
    bus(0, 3'd0, 0, rd); check("w1c vs edge", rd, 24'h08);
    bus(1, 3'd0, 24'h08, rd);
    bus(0, 3'd0, 0, rd); check("w1c plain", rd, 24'h00);

    // clken low during an edge; latency counts only enabled cycles
    irq = 8'h00;
    repeat (3) tick();
    clken = 1'b0;
    irq   = 8'h08;
    repeat (5) tick();
    bus(0, 3'd0, 0, rd); check("clken hold pend", rd, 24'h00);
    check("clken hold int_b", int_b, 1'b1);
    clken = 1'b1;
    tick();
    tick();
    bus(0, 3'd0, 0, rd); check("clken pend k+1", rd, 24'h00);
    bus(0, 3'd0, 0, rd); check("clken pend k+2", rd, 24'h08);
    check("clken int_b k+3", int_b, 1'b0);
    irq = 8'h00;
    bus(1, 3'd0, 24'h08, rd);
    tick();
    check("clken cleared int_b", int_b, 1'b1);

    // Address decode
    address = BASE | 24'h7; rnw = 1'b1; vda = 1'b1;
    #1;
    check("reg7 sel", sel, 1'b1);
    check("reg7 dout", dout, 24'h0);
    tick();
    address = BASE + 24'h8;
    #1;
    check("outside sel", sel, 1'b0);
    check("outside dout", dout, 24'h0);
    address = BASE | 24'h1; vda = 1'b0;
    #1;
    check("no vda sel", sel, 1'b0);
    check("no vda dout", dout, 24'h0);

    // Reset with two channels in service and int_b low
    bus(1, 3'd2, 24'h00, rd);
    irq = 8'h02;
    repeat (4) tick();
    check("rst setup int_b a", int_b, 1'b0);
    bus(0, 3'd3, 0, rd); check("rst claim1", rd, 24'h800001);
    irq = 8'h03;
    repeat (4) tick();
    check("rst setup int_b b", int_b, 1'b0);
    bus(0, 3'd3, 0, rd); check("rst claim0", rd, 24'h800000);
    address = BASE | 24'h5; rnw = 1'b1; vda = 1'b1;
    #1;
    check("rst pre insvc", dout, 24'h03);
    check("rst pre int_b", int_b, 1'b0);
    vda = 1'b0; reset_b = 1'b0; irq = 8'h00;
    tick();
    reset_b = 1'b1;
    check("rst int_b", int_b, 1'b1);
    check("rst vector", vector, VEC_BASE);
    bus(0, 3'd0, 0, rd); check("rst PEND", rd, 24'h0);
    bus(0, 3'd1, 0, rd); check("rst MASK", rd, 24'h0);
    bus(0, 3'd2, 0, rd); check("rst MODE", rd, 24'h0);
    bus(0, 3'd5, 0, rd); check("rst INSVC", rd, 24'h0);

    // Randomized traffic against the model
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      reset_b = ($urandom_range(0, 199) != 0);
      clken   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) irq = irq ^ (8'h01 << $urandom_range(0, 7));
      vda     = ($urandom_range(0, 2) != 0);
      address = ($urandom_range(0, 7) == 0) ? 24'($urandom) : (BASE | 24'($urandom_range(0, 7)));
      rnw     = ($urandom_range(0, 1) != 0);
      din     = 24'($urandom);
      #1;
      check("rnd sel", sel, m_sel());
      check("rnd dout", dout, m_dout());
      check("rnd int_b", int_b, m_int_b);
      check("rnd vector", vector, m_vector());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opc_intctl.md
# opc_intctl

Parametrised vectored interrupt controller for the OPC CPU family. It generalises the CPU's fixed two-line, two-vector interrupt scheme to NCHAN prioritised channels with:
- per-channel mask and edge/level mode;
- pending and in-service tracking;
- nested preemption.

It sits on the CPU data bus as a memory-mapped slave. It drives a single active-low request into the CPU's interrupt input and presents the winning vector for the handler to read.

## Interface
- WIDTH, 24, data/address width (matches CPU word).
- NCHAN, 8, interrupt channels, 1..WIDTH-1; channel 0 is highest priority.
- BASE, 24'hFFFF00, register block base address (8-word aligned).
- VEC_BASE, 24'h000010, vector of channel 0.
- VEC_STRIDE, 2, words between consecutive channel vectors.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  synchronous active-low reset, sampled on rising clk (independent of clken).
- clken  in  1  clock enable; when low all state holds.
- irq  in  NCHAN  asynchronous interrupt sources, active high.
- address  in  WIDTH  CPU bus address.
- din  in  WIDTH  CPU write data.
- rnw  in  1  1=read, 0=write.
- vda  in  1  valid data address strobe.
- dout  out  WIDTH  read data; 0 when not selected (OR-able onto bus).
- sel  out  1  high when vda && address[WIDTH-1:3]==BASE[WIDTH-1:3].
- int_b  out  1  active-low interrupt request to CPU.
- vector  out  WIDTH  VEC_BASE + id*VEC_STRIDE for current winner id.

## Operation
Registers, selected by address[2:0]:
- 0 PEND: read. Write-1-to-clear edge channels; writes to level channels are ignored.
- 1 MASK: read/write, 1=enabled.
- 2 MODE: read/write, 1=edge, 0=level.
- 3 ID: read returns {valid in bit WIDTH-1, id in low bits}. The read is the claim.
- 4 EOI: any write clears the highest-priority in-service bit.
- 5 INSVC: read only.
- 6 VECTOR: read only.
- 7: reads 0, writes ignored.

Channel behaviour:
- Each irq passes a 2-flop synchroniser, then a previous-value flop for edge detection.
- Edge channel: a rising synchronised edge sets pend. Pend is cleared by W1C or by claim.
- Level channel: pend equals the synchronised level.

Arbitration:
- Candidate = pend & MASK & (channel index < index of highest-priority INSVC bit). All channels qualify when INSVC==0.
- Winner id = lowest-index candidate; valid = any candidate.
- int_b is registered: next value is !valid.

Claim:
- Condition: a read of ID (sel && rnw && address[2:0]==3 && clken).
- With valid: set INSVC[id]. If the channel is edge, clear pend[id].
- Without valid: returns 0, no side effect.

EOI behaviour:
- With INSVC==0: no effect.
- Claim and EOI in the same cycle cannot occur (one bus access per cycle).

Precedence:
- A new edge on the same cycle as a W1C of that bit: set wins.
- A new edge on the same cycle as a claim of that channel: pend stays set.

Read data and register writes:
- Read data is combinational from address/state.
- All register writes and side effects take place on rising clk with clken high.

Reset values (after reset_b low at a clk edge):
- PEND, MASK, MODE, INSVC and synchroniser/edge flops are 0.
- int_b=1; dout=0 when not selected.
- vector=VEC_BASE.
- Reset mid-operation discards all in-service state.

## Timing
- irq rise sampled at edge k: sync at k+1, pend at k+2, int_b low after edge k+3 (3 enabled cycles).
- Cycles with clken low do not count toward this latency.
- Claim at edge c: int_b reflects the new arbitration after edge c+1.
- EOI at edge e: int_b reflects the new arbitration after edge e+1.
- MASK/MODE writes affect arbitration on the next cycle.
- The MODE change edge→level leaves pend following the level from the next cycle.
- vector and ID are combinational on current pend/MASK/INSVC.
- The handler must read ID before relying on vector contents.

## Test plan
- Reset, MASK=0x01, MODE=0x01, pulse irq[0] for 1 cycle -> pend[0]=1 at k+2, int_b=0 at k+3. ID read returns 0x800000, INSVC=0x01, pend[0]=0, int_b=1 next cycle. EOI -> INSVC=0.
- MASK=0xFF, irq[5] level high, claim (ID=0x800005) -> int_b=1. Raise irq[2] -> int_b=0; ID=0x800002, vector=0x000014, INSVC=0x24. EOI -> INSVC=0x20; EOI -> 0. With irq[5] still high, int_b=0 again.
- Preemption blocked: INSVC[2]=1, raise level irq[6] -> int_b stays 1, ID read returns 0 with no INSVC change.
- W1C collision: edge channel 3, write PEND=0x08 on the same cycle a new edge reaches pend -> pend[3]=1. Plain W1C without an edge -> pend[3]=0.
- clken held low 5 cycles during an irq edge -> no state change; latency counts only enabled cycles. Address BASE+7 read -> dout=0, sel=1. Address outside block -> sel=0, dout=0.
- reset_b low for one cycle while INSVC=0x03 and int_b=0 -> all registers 0, int_b=1 after that edge.
